// File: rtl/regfile_mp_clr.sv
// rtl/regfile_mp_clr.sv - multi-read-port register file with hardware clear sequencer
//
// Purpose: single-write, NUM_RD-read register file for the ID stage. After reset
// or a Clear request, a sequencer zeroes one entry per clock. Ready rises on the
// edge that zeroes the last entry. Register 0 can be hardwired to zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined: write-through forwarding of busW to any read port addressing Rw.
//   Undefined: reads always return the stored value.
//
// Ports:
//   Clk       in   1              rising-edge clock
//   Rst_n     in   1              asynchronous active-low reset
//   Run       in   1              0 = reads return 0 and writes are dropped
//   Clear     in   1              restart the clear sequence (wins over a write)
//   Raddr     in   NUM_RD*AW      packed read addresses, port i at [i*AW +: AW]
//   Rdata     out  NUM_RD*WIDTH   packed read data, port i at [i*WIDTH +: WIDTH]
//   Rw        in   AW             write address
//   busW      in   WIDTH          write data
//   RegWr     in   1              write enable
//   Overflow  in   1              ALU overflow, suppresses the write
//   Ready     out  1              clear sequence complete

module regfile_mp_clr #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Run,
    input  logic                    Clear,
    input  logic [NUM_RD*AW-1:0]    Raddr,
    output logic [NUM_RD*WIDTH-1:0] Rdata,
    input  logic [AW-1:0]           Rw,
    input  logic [WIDTH-1:0]        busW,
    input  logic                    RegWr,
    input  logic                    Overflow,
    output logic                    Ready
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_idx;
    logic               r_ready;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_zero_wr;
    logic               w_wr_commit;

    // A write to the hardwired zero register is dropped rather than stored.
    assign w_zero_wr   = (ZERO_REG != 0) && (Rw == '0);
    assign w_wr_commit = (r_state == S_READY) && Run && RegWr && !Overflow
                         && !Clear && !w_zero_wr;

    // Sequencer: the index walks all entries once; the edge that clears the last
    // entry also moves to READY, so Ready rises DEPTH edges after the restart.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else if (Clear) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_idx <= r_idx + AW'(1);
            if (r_idx == AW'(DEPTH - 1)) begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end
    end

    // Storage has no reset; the sequencer is the only initialisation path.
    // While Clear is high nothing is written, so a colliding write is lost.
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_idx] <= '0;
            end else if (w_wr_commit) begin
                r_mem[Rw] <= busW;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]    w_raddr;
        logic [WIDTH-1:0] w_rdata;

        assign w_raddr = Raddr[gi*AW +: AW];

        always_comb begin
            w_rdata = r_mem[w_raddr];
            if (!r_ready || !Run || ((ZERO_REG != 0) && (w_raddr == '0))) begin
                w_rdata = '0;
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the write committing on the next edge (WB-to-ID in one cycle).
            else if (w_wr_commit && (Rw == w_raddr)) begin
                w_rdata = busW;
            end
`endif
        end

        assign Rdata[gi*WIDTH +: WIDTH] = w_rdata;
    end

    assign Ready = r_ready;

endmodule

// File: tb/tb_regfile_mp_clr.sv
// tb/tb_regfile_mp_clr.sv - scoreboard bench for regfile_mp_clr (ZERO_REG=1 and ZERO_REG=0 instances)

module tb_regfile_mp_clr;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           clk;
    logic           rst_n;
    logic           run;
    logic           clear;
    logic [NR*AW-1:0] raddr;
    logic [AW-1:0]  rw;
    logic [W-1:0]   busw;
    logic           regwr;
    logic           ovf;
    logic [NR*W-1:0] rdata_z;
    logic [NR*W-1:0] rdata_n;
    logic           ready_z;
    logic           ready_n;

    regfile_mp_clr #(.WIDTH(W), .DEPTH(D), .AW(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
        .Clk(clk), .Rst_n(rst_n), .Run(run), .Clear(clear), .Raddr(raddr),
        .Rdata(rdata_z), .Rw(rw), .busW(busw), .RegWr(regwr), .Overflow(ovf),
        .Ready(ready_z)
    );

    regfile_mp_clr #(.WIDTH(W), .DEPTH(D), .AW(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_n (
        .Clk(clk), .Rst_n(rst_n), .Run(run), .Clear(clear), .Raddr(raddr),
        .Rdata(rdata_n), .Rw(rw), .busW(busw), .RegWr(regwr), .Overflow(ovf),
        .Ready(ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: kind 0 = read data on a port, kind 1 = Ready.
    typedef struct {
        int          inst;
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: instance 0 has a zero register, instance 1 does not.
    // A clear request is modelled as instantly wiping the file; the sequencer's
    // gradual zeroing is invisible because reads are 0 until Ready.
    logic [31:0] m_mem [2][D];
    int          m_cnt;
    bit          m_ready;

    task automatic m_reset();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < D; j++)
                m_mem[i][j] = 32'h0;
        m_cnt   = 0;
        m_ready = 1'b0;
    endtask

    function automatic logic [31:0] m_read(int inst, logic [AW-1:0] a);
        if (!m_ready || !run || (inst == 0 && a == 0)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (regwr && !ovf && !clear && rw == a && !(inst == 0 && rw == 0)) return busw;
`endif
        return m_mem[inst][a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n || clear) begin
            m_reset();
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == D) m_ready = 1'b1;
        end else if (regwr && !ovf && run) begin
            for (int i = 0; i < 2; i++)
                if (!(i == 0 && rw == 0)) m_mem[i][rw] = busw;
        end
        #1;
    endtask

    task automatic chk(input string nm);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.inst = i; e.kind = 1; e.port = 0; e.exp = {31'h0, m_ready}; e.name = nm;
            sbq.push_back(e);
            for (int p = 0; p < NR; p++) begin
                e.kind = 0; e.port = p; e.exp = m_read(i, raddr[p*AW +: AW]);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        rw = a; busw = d; regwr = 1'b1;
    endtask

    task automatic idle();
        regwr = 1'b0;
    endtask

    // Monitor: compares every queued expectation against the DUT outputs,
    // away from the active edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.kind == 1)
                    act = {31'h0, (e.inst == 0) ? ready_z : ready_n};
                else
                    act = (e.inst == 0) ? rdata_z[e.port*W +: W] : rdata_n[e.port*W +: W];
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: inst%0d kind%0d port%0d got %h expected %h at %0t",
                             e.name, e.inst, e.kind, e.port, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        rst_n = 1'b0; run = 1'b1; clear = 1'b0; raddr = '0; rw = '0;
        busw = '0; regwr = 1'b0; ovf = 1'b0;
        m_reset();

        repeat (3) begin chk("reset"); tick(); end
        n_checks++;
        if (ready_z !== 1'b0 || ready_n !== 1'b0 || rdata_z !== '0 || rdata_n !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready %b/%b rdata %h/%h at %0t",
                     ready_z, ready_n, rdata_z, rdata_n, $time);
        end
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin rd(5'(i), 5'(D-1-i)); chk("clear_seq"); tick(); end
        chk("ready_up");

        for (int a = 0; a < D; a++) begin rd(5'(a), 5'(D-1-a)); chk("all_zero"); tick(); end

        wr(5, 32'hDEADBEEF); tick(); idle();
        rd(0, 5); chk("wr_r5"); tick();

        ovf = 1'b1; wr(5, 32'h12345678); tick(); ovf = 1'b0; idle();
        chk("ovf_block"); tick();

        run = 1'b0; wr(5, 32'h12345678); chk("run0_read"); tick(); idle();
        chk("run0_read2"); tick();
        run = 1'b1; chk("run0_block"); tick();

        wr(0, 32'hFFFFFFFF); tick(); idle();
        rd(0, 0); chk("zero_reg"); tick();

        wr(7, 32'hA5A5A5A5); tick();
        wr(3, 32'h1); clear = 1'b1; tick(); clear = 1'b0; idle();
        rd(3, 7); chk("clear_drop"); tick();
        repeat (D-1) begin chk("clear_seq2"); tick(); end
        chk("clear_done"); tick();

        clear = 1'b1; repeat (3) begin chk("clear_hold"); tick(); end
        clear = 1'b0;
        repeat (D-1) begin chk("clear_hold_seq"); tick(); end
        chk("clear_hold_last"); tick();
        chk("clear_hold_done"); tick();

        wr(9, 32'h11); tick();
        wr(9, 32'h22); rd(9, 9); chk("same_addr"); tick(); idle();
        chk("same_addr_after"); tick();

        // Reset asserted mid-sequence with a write pending.
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (10) begin chk("pre_rst_seq"); tick(); end
        wr(4, 32'h55); #2; rst_n = 1'b0; m_reset(); chk("rst_async"); tick();
        idle(); rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin rd(4, 5'(i)); chk("rst_seq"); tick(); end
        chk("rst_done"); tick();

        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 59) == 0);
            regwr = 1'($urandom_range(0, 1));
            ovf   = ($urandom_range(0, 3) == 0);
            run   = ($urandom_range(0, 7) != 0);
            rw    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, D-1));
            busw  = $urandom;
            raddr[0 +: AW]  = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, D-1));
            raddr[AW +: AW] = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, D-1));
            chk("random");
            tick();
        end

        clear = 1'b0; idle();
        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations unchecked at %0t", sbq.size(), $time);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
